// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between the core load/store
// path (master) and the data memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we, req_funct3  : store flag and RV32I access-size encoding
//   req_addr, req_wdata : byte address and right-aligned store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : extended load data and error flag
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the CPU data path.
// Word-addressed RAM with byte-lane writes, configurable wait states,
// load extraction with sign/zero extension, and misalignment /
// illegal-funct3 error reporting. One request outstanding at a time.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (RAM contents are kept)
//   bus    : data_mem_responder_if slave port (request + response)
module data_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    data_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            cnt;
    // ACCESS spans two cycles: phase 0 performs the RAM operation, phase 1
    // registers the extracted load data so it is stable on entry to RESP.
    logic                  acc_ph;
    logic                  err_q;
    logic [31:0]           rdata_q;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_word;
    logic [ADDR_WIDTH-3:0] idx;

    logic                  acc_err;
    logic [3:0]            be;
    logic [31:0]           wdat;
    logic                  wr_en;
    logic                  rd_en;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           ld_data;

    assign idx = addr_q[ADDR_WIDTH-1:2];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = (LATENCY == 0) ? ACCESS : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
            ACCESS:  if (acc_ph) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready = (state == IDLE) && rst_ni;
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    // ---------------- request latch, wait counter, response regs ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cnt     <= 4'd0;
            acc_ph  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            acc_ph <= (state == ACCESS) && !acc_ph;
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    f3_q    <= bus.req_funct3;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    cnt     <= CNT_LOAD;
                end
                WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                ACCESS: if (acc_ph) begin
                    err_q   <= acc_err;
                    rdata_q <= (acc_err || we_q) ? 32'd0 : ld_data;
                end
                RESP: if (bus.rsp_ready) begin
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- error check on the latched request ----------------
    always_comb begin
        logic illegal, misal;
        illegal = we_q ? (f3_q > 3'd2)
                       : (f3_q == 3'd3 || f3_q == 3'd6 || f3_q == 3'd7);
        misal   = ((f3_q[1:0] == 2'd1) && addr_q[0]) ||
                  ((f3_q[1:0] == 2'd2) && (addr_q[1:0] != 2'd0));
        acc_err = illegal || misal;
    end

    // ---------------- store lane enables and replicated data ----------------
    always_comb begin
        be   = 4'b0000;
        wdat = wdata_q;
        case (f3_q[1:0])
            2'd0: begin
                be   = 4'b0001 << addr_q[1:0];
                wdat = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wdat = {2{wdata_q[15:0]}};
            end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // rst_ni gating keeps a write from slipping through while reset is held.
    assign wr_en = (state == ACCESS) && !acc_ph && we_q && !acc_err && rst_ni;
    assign rd_en = (state == ACCESS) && !acc_ph && !we_q;

    // ---------------- RAM (not reset) ----------------
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
        end
        if (rd_en) rd_word <= mem[idx];
    end

    // ---------------- load extraction ----------------
    always_comb begin
        byte_sel = rd_word[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (f3_q)
            3'd0:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    ld_data = {{16{half_sel[15]}}, half_sel};
            3'd2:    ld_data = rd_word;
            3'd4:    ld_data = {24'd0, byte_sel};
            3'd5:    ld_data = {16'd0, half_sel};
            default: ld_data = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench for data_mem_responder. Two
// instances (LATENCY=1 and LATENCY=3) share stimulus; sel picks which one
// receives req_valid and which one's outputs are observed.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic        rready = 1'b1;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_WIDTH(16)) b1 ();
    data_mem_responder_if #(.ADDR_WIDTH(16)) b3 ();

    assign b1.req_valid  = valid & ~sel;
    assign b3.req_valid  = valid & sel;
    assign b1.req_we     = we;
    assign b3.req_we     = we;
    assign b1.req_funct3 = f3;
    assign b3.req_funct3 = f3;
    assign b1.req_addr   = addr;
    assign b3.req_addr   = addr;
    assign b1.req_wdata  = wdata;
    assign b3.req_wdata  = wdata;
    assign b1.rsp_ready  = rready;
    assign b3.rsp_ready  = rready;

    data_mem_responder #(.ADDR_WIDTH(16), .LATENCY(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b1));
    data_mem_responder #(.ADDR_WIDTH(16), .LATENCY(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b3));

    logic        rq_ready, rv, rerr;
    logic [31:0] rdata;
    assign rq_ready = sel ? b3.req_ready : b1.req_ready;
    assign rv       = sel ? b3.rsp_valid : b1.rsp_valid;
    assign rerr     = sel ? b3.rsp_err   : b1.rsp_err;
    assign rdata    = sel ? b3.rsp_rdata : b1.rsp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait for accept, then count edges until rsp_valid.
    // Leaves rsp_ready high so the response is consumed on the next edge.
    task automatic issue(input logic w, input logic [2:0] f, input logic [15:0] a,
                         input logic [31:0] d, output int lat);
        int n;
        we = w; f3 = f; addr = a; wdata = d; valid = 1'b1;
        n = 0;
        while (!rq_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", {31'd0, n < 20}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        lat = 0;
        while (!rv && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    endtask

    task automatic xact(input string tag, input logic w, input logic [2:0] f,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        rready = 1'b1;
        issue(w, f, a, d, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_err"}, {31'd0, rerr}, {31'd0, exp_err});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic seen;

        // reset state
        @(negedge clk);
        chk("rst_req_ready", {31'd0, rq_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rv}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, rerr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, rq_ready}, 32'd1);

        // LATENCY=1
        xact("sw10",   1'b1, 3'd2, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0, 3);
        xact("lw10",   1'b0, 3'd2, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 3);
        xact("sb12",   1'b1, 3'd0, 16'h0012, 32'h00000080, 32'h00000000, 1'b0, 3);
        xact("lb12",   1'b0, 3'd0, 16'h0012, 32'h0,        32'hFFFFFF80, 1'b0, 3);
        xact("lbu12",  1'b0, 3'd4, 16'h0012, 32'h0,        32'h00000080, 1'b0, 3);
        xact("lw10b",  1'b0, 3'd2, 16'h0010, 32'h0,        32'hDE80BEEF, 1'b0, 3);
        xact("sw14",   1'b1, 3'd2, 16'h0014, 32'h11223344, 32'h00000000, 1'b0, 3);
        xact("sh16",   1'b1, 3'd1, 16'h0016, 32'h00008001, 32'h00000000, 1'b0, 3);
        xact("lh16",   1'b0, 3'd1, 16'h0016, 32'h0,        32'hFFFF8001, 1'b0, 3);
        xact("lhu16",  1'b0, 3'd5, 16'h0016, 32'h0,        32'h00008001, 1'b0, 3);
        xact("lh15",   1'b0, 3'd1, 16'h0015, 32'h0,        32'h00000000, 1'b1, 3);
        xact("lw14",   1'b0, 3'd2, 16'h0014, 32'h0,        32'h80013344, 1'b0, 3);
        xact("st_f3",  1'b1, 3'd3, 16'h0010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3);
        xact("sw_mis", 1'b1, 3'd2, 16'h0012, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3);
        xact("ld_f3",  1'b0, 3'd6, 16'h0010, 32'h0,        32'h00000000, 1'b1, 3);
        xact("lw10c",  1'b0, 3'd2, 16'h0010, 32'h0,        32'hDE80BEEF, 1'b0, 3);

        // backpressure: response held for 5 cycles
        rready = 1'b0;
        issue(1'b0, 3'd2, 16'h0010, 32'h0, lat);
        chk("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rv}, 32'd1);
            chk("bp_rdata", rdata, 32'hDE80BEEF);
            chk("bp_err", {31'd0, rerr}, 32'd0);
            chk("bp_req_ready", {31'd0, rq_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_rel_valid", {31'd0, rv}, 32'd0);
        chk("bp_rel_ready", {31'd0, rq_ready}, 32'd1);

        // LATENCY=3
        sel = 1'b1;
        @(negedge clk);
        xact("l3_sw20", 1'b1, 3'd2, 16'h0020, 32'hCAFEF00D, 32'h00000000, 1'b0, 5);
        xact("l3_lw20", 1'b0, 3'd2, 16'h0020, 32'h0,        32'hCAFEF00D, 1'b0, 5);

        // reset pulse during WAIT of a store
        we = 1'b1; f3 = 3'd2; addr = 16'h0020; wdata = 32'h12345678; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, rq_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rel_ready", {31'd0, rq_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rv) seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_no_rsp", {31'd0, seen}, 32'd0);
        xact("l3_lw20b", 1'b0, 3'd2, 16'h0020, 32'h0, 32'hCAFEF00D, 1'b0, 5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU load/store path. It is the memory end of the data interface the core drives today: word-addressed RAM, funct3-encoded access size, byte-lane writes.
- Adds a valid/ready request/response handshake, configurable wait states, byte-lane write enables, load extraction with sign/zero extension, and misalignment/illegal-size error reporting.
- Sits between the core's load/store path and the data RAM. One request outstanding at a time.

Parameters:
- ADDR_WIDTH, 16, byte-address width; RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 1, extra wait-state cycles inserted before the RAM access (0..15).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  RV32I load/store funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  initiator accepts response.
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  access was misaligned or had an illegal funct3.

Behaviour:
- Reset values: req_ready_o=0 while rst_ni=0; after reset, 1 in IDLE. rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FSM=IDLE, wait counter=0.
- RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o, latch we, funct3, addr and wdata.
  - If LATENCY=0, go to ACCESS; else load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready_o=0.
  - Decrement the counter; at 0, go to ACCESS.
  - Total WAIT cycles = LATENCY.
- ACCESS:
  - Error check on the latched request. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Illegal means funct3 is 3, 6 or 7 for a load, or >2 for a store.
  - On error: no RAM write; go to RESP with err=1, rdata=0.
  - Store: write word addr[ADDR_WIDTH-1:2] with byte enables. SB sets enable bit addr[1:0] with wdata[7:0] replicated. SH sets enables 0011 or 1100 per addr[1] with wdata[15:0] replicated. SW sets 1111.
  - Load: synchronous RAM read issued this cycle.
  - Next state: RESP.
- RESP:
  - rsp_valid_o=1; rdata/err are held stable while rsp_ready_i=0.
  - Load data is extracted from the read word by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - rdata is registered at entry to RESP.
  - On rsp_ready_i, go to IDLE and clear rsp_valid_o next cycle. req_ready_o stays 0 in RESP; there is no same-cycle back-to-back accept.
- Latency: request accepted at edge T gives rsp_valid_o high after edge T+2+LATENCY.
- Address bits above ADDR_WIDTH do not exist; there is no out-of-range error.
- Reset mid-operation: FSM returns to IDLE immediately, the pending request is dropped with no response, and no write occurs if rst_ni is low at the ACCESS edge.
- req_valid_i while not ready is ignored; the initiator must hold it.
- Inputs other than the latched copies are don't-care outside the IDLE handshake.

Test Plan:
- LATENCY=1: SW addr 0x0010 data 0xDEADBEEF, then LW 0x0010 -> rsp_rdata_o=0xDEADBEEF, err=0. Each rsp_valid_o appears 3 cycles after its accept.
- SB 0x0012 data 0x00000080, then LB 0x0012 -> 0xFFFFFF80; LBU 0x0012 -> 0x00000080; LW 0x0010 -> 0xDE80BEEF.
- SH 0x0016 data 0x8001, then LH 0x0016 -> 0xFFFF8001; LHU -> 0x00008001; LH 0x0015 -> err=1, rdata=0, memory unchanged.
- Illegal funct3: store with funct3=3 -> err=1 and no write; a following LW of the same word returns the prior value.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rdata and err stable, req_ready_o=0. Release -> IDLE next cycle, req_ready_o=1.
- LATENCY=3: accept at T gives rsp_valid_o at T+5. Pulse rst_ni low during WAIT of a SW -> no response, targeted word unchanged, req_ready_o=1 one cycle after release.
